// File: rtl/rformat_pkg.sv
// Shared constants for the R-format execute controller: opcode/funct codes,
// ALU control encodings, the instruction field layout and the FSM state encoding.
package rformat_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rinstr_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_READ    = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_WRITE   = 3'd4;
  localparam logic [2:0] ST_ILLEGAL = 3'd5;

endpackage

// File: rtl/rformat_funct_decoder.sv
// Combinational {opcode, funct} -> {ALU operation, legal} decode for R-format instructions.
module rformat_funct_decoder
  import rformat_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_operation,
  output logic       o_legal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_alu_operation = 4'b0000;
    o_legal         = 1'b1;
    unique case (i_funct)
      FUNCT_ADD: o_alu_operation = ALU_ADD;
      FUNCT_SUB: o_alu_operation = ALU_SUB;
      FUNCT_AND: o_alu_operation = ALU_AND;
      FUNCT_OR:  o_alu_operation = ALU_OR;
      FUNCT_NOR: o_alu_operation = ALU_NOR;
      FUNCT_SLT: o_alu_operation = ALU_SLT;
      default:   o_legal         = 1'b0;
    endcase
    if (i_opcode != OPCODE_RTYPE) begin
      o_legal         = 1'b0;
      o_alu_operation = 4'b0000;
    end
  end

endmodule

// File: rtl/rformat_exec_controller.sv
// Multi-cycle R-format sequencer: IDLE -> DECODE -> READ -> EXEC(xALU_LATENCY) -> WRITE.
// Define RFX_PERF_CNT_EN to add the retired_count / illegal_count performance counters.
module rformat_exec_controller
  import rformat_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset_input,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rs_address,
  output logic [ADDR_W-1:0] rt_address,
  output logic [ADDR_W-1:0] rd_address,
  output logic              operand_latch,
  output logic [3:0]        ALU_operation,
  output logic              write_enabled,
  output logic              done,
  output logic              illegal_instr
`ifdef RFX_PERF_CNT_EN
  ,
  output logic [31:0]       retired_count,
  output logic [15:0]       illegal_count
`endif
);

  localparam logic [3:0] EXEC_LOAD = 4'(ALU_LATENCY - 1);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  rinstr_t    r_instr;
  logic [3:0] r_exec_cnt;
  logic [3:0] w_alu_op;
  logic       w_legal;
  logic       w_accept;
  logic       w_busy;
  logic       w_unused_shamt;

  rformat_funct_decoder u_decoder (
    .i_opcode        (r_instr.opcode),
    .i_funct         (r_instr.funct),
    .o_alu_operation (w_alu_op),
    .o_legal         (w_legal)
  );

  // abort in IDLE blocks an offered instruction in the same cycle.
  assign w_accept       = instr_valid && (r_state == ST_IDLE) && !abort;
  assign w_busy         = (r_state != ST_IDLE);
  assign w_unused_shamt = ^r_instr.shamt;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next_state = ST_DECODE;
      ST_DECODE:  w_next_state = abort ? ST_IDLE : (w_legal ? ST_READ : ST_ILLEGAL);
      ST_READ:    w_next_state = abort ? ST_IDLE : ST_EXEC;
      ST_EXEC:    if (abort) w_next_state = ST_IDLE;
                  else if (r_exec_cnt == 4'd0) w_next_state = ST_WRITE;
      ST_WRITE:   w_next_state = ST_IDLE;
      ST_ILLEGAL: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset_input) begin
    if (reset_input) begin
      r_state    <= ST_IDLE;
      r_instr    <= '0;
      r_exec_cnt <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) r_instr <= rinstr_t'(instr);
      if (r_state == ST_READ) r_exec_cnt <= EXEC_LOAD;
      else if (r_state == ST_EXEC && r_exec_cnt != 4'd0) r_exec_cnt <= r_exec_cnt - 4'd1;
    end
  end

  assign instr_ready   = (r_state == ST_IDLE);
  assign rs_address    = w_busy ? ADDR_W'(r_instr.rs) : '0;
  assign rt_address    = w_busy ? ADDR_W'(r_instr.rt) : '0;
  assign rd_address    = w_busy ? ADDR_W'(r_instr.rd) : '0;
  assign ALU_operation = w_busy ? w_alu_op : 4'b0000;
  assign operand_latch = (r_state == ST_READ);
  assign done          = (r_state == ST_WRITE);
  assign write_enabled = (r_state == ST_WRITE) && (r_instr.rd != 5'd0);
  assign illegal_instr = (r_state == ST_ILLEGAL) && !abort;

`ifdef RFX_PERF_CNT_EN
  logic [31:0] r_retired_count;
  logic [15:0] r_illegal_count;

  always_ff @(posedge clk or posedge reset_input) begin
    if (reset_input) begin
      r_retired_count <= '0;
      r_illegal_count <= '0;
    end else begin
      if (done) r_retired_count <= r_retired_count + 32'd1;
      if (illegal_instr && r_illegal_count != 16'hFFFF) r_illegal_count <= r_illegal_count + 16'd1;
    end
  end

  assign retired_count = r_retired_count;
  assign illegal_count = r_illegal_count;
`endif

endmodule
